// File: rtl/memory_arbiter.sv
// Two-port (instruction fetch / load-store) arbiter onto one shared memory bus with an access timeout.
// Define ROUND_ROBIN_EN to alternate grants on simultaneous requests; otherwise the data port always wins.
module memory_arbiter #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_req,
    input  logic [ADDRESS_WIDTH-1:0] i_address,
    output logic [DATA_WIDTH-1:0]    i_data,
    output logic                     i_ack,
    output logic                     i_err,
    input  logic                     d_req,
    input  logic                     d_we,
    input  logic [ADDRESS_WIDTH-1:0] d_address,
    input  logic [DATA_WIDTH-1:0]    d_write_data,
    output logic [DATA_WIDTH-1:0]    d_read_data,
    output logic                     d_ack,
    output logic                     d_err,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_write_data,
    input  logic [DATA_WIDTH-1:0]    mem_read_data,
    input  logic                     mem_ack
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    state_t                   state_q, state_d;
    logic [15:0]              count_q, count_d;
    logic                     grant_data_q, grant_data_d;
    logic                     mem_req_q, mem_req_d;
    logic                     mem_we_q, mem_we_d;
    logic [ADDRESS_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0]    mem_write_data_q, mem_write_data_d;
    logic [DATA_WIDTH-1:0]    i_data_q, i_data_d;
    logic [DATA_WIDTH-1:0]    d_read_data_q, d_read_data_d;
    logic                     i_ack_q, i_ack_d, i_err_q, i_err_d;
    logic                     d_ack_q, d_ack_d, d_err_q, d_err_d;
    logic                     pick_data;
    logic [15:0]              count_next;

`ifdef ROUND_ROBIN_EN
    logic last_grant_data_q, last_grant_data_d;

    always_comb begin
        if (i_req && d_req) pick_data = !last_grant_data_q;
        else                pick_data = d_req;
    end
`else
    assign pick_data = d_req;
`endif

    assign count_next = count_q + 16'd1;

    always_comb begin
        // NOTE: every signal gets its default first so no path through the case infers a latch.
        state_d          = state_q;
        count_d          = count_q;
        grant_data_d     = grant_data_q;
        mem_req_d        = mem_req_q;
        mem_we_d         = mem_we_q;
        mem_address_d    = mem_address_q;
        mem_write_data_d = mem_write_data_q;
        i_data_d         = i_data_q;
        d_read_data_d    = d_read_data_q;
        i_ack_d          = 1'b0;
        i_err_d          = 1'b0;
        d_ack_d          = 1'b0;
        d_err_d          = 1'b0;
`ifdef ROUND_ROBIN_EN
        last_grant_data_d = last_grant_data_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    state_d          = ACCESS;
                    count_d          = 16'd0;
                    grant_data_d     = pick_data;
                    mem_req_d        = 1'b1;
                    mem_we_d         = pick_data ? d_we : 1'b0;
                    mem_address_d    = pick_data ? d_address : i_address;
                    mem_write_data_d = pick_data ? d_write_data : '0;
`ifdef ROUND_ROBIN_EN
                    last_grant_data_d = pick_data;
`endif
                end
            end
            ACCESS: begin
                // A mem_ack in the timeout cycle takes precedence over the error.
                if (mem_ack) begin
                    state_d   = RESPOND;
                    mem_req_d = 1'b0;
                    if (grant_data_q) begin
                        d_ack_d = 1'b1;
                        if (!mem_we_q) d_read_data_d = mem_read_data;
                    end else begin
                        i_ack_d  = 1'b1;
                        i_data_d = mem_read_data;
                    end
                end else begin
                    count_d = count_next;
                    if (count_next == TIMEOUT_LIMIT) begin
                        state_d   = RESPOND;
                        mem_req_d = 1'b0;
                        if (grant_data_q) begin
                            d_ack_d       = 1'b1;
                            d_err_d       = 1'b1;
                            d_read_data_d = '0;
                        end else begin
                            i_ack_d  = 1'b1;
                            i_err_d  = 1'b1;
                            i_data_d = '0;
                        end
                    end
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            count_q          <= 16'd0;
            grant_data_q     <= 1'b0;
            mem_req_q        <= 1'b0;
            mem_we_q         <= 1'b0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
            i_data_q         <= '0;
            d_read_data_q    <= '0;
            i_ack_q          <= 1'b0;
            i_err_q          <= 1'b0;
            d_ack_q          <= 1'b0;
            d_err_q          <= 1'b0;
`ifdef ROUND_ROBIN_EN
            last_grant_data_q <= 1'b1;
`endif
        end else begin
            state_q          <= state_d;
            count_q          <= count_d;
            grant_data_q     <= grant_data_d;
            mem_req_q        <= mem_req_d;
            mem_we_q         <= mem_we_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
            i_data_q         <= i_data_d;
            d_read_data_q    <= d_read_data_d;
            i_ack_q          <= i_ack_d;
            i_err_q          <= i_err_d;
            d_ack_q          <= d_ack_d;
            d_err_q          <= d_err_d;
`ifdef ROUND_ROBIN_EN
            last_grant_data_q <= last_grant_data_d;
`endif
        end
    end

    assign i_data         = i_data_q;
    assign i_ack          = i_ack_q;
    assign i_err          = i_err_q;
    assign d_read_data    = d_read_data_q;
    assign d_ack          = d_ack_q;
    assign d_err          = d_err_q;
    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_address    = mem_address_q;
    assign mem_write_data = mem_write_data_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter (TIMEOUT_CYCLES=4); grant-order expectations follow ROUND_ROBIN_EN.
module tb_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we, mem_ack;
    logic [31:0] i_address, d_address, d_write_data, mem_read_data;
    logic [31:0] i_data, d_read_data, mem_address, mem_write_data;
    logic        i_ack, i_err, d_ack, d_err, mem_req, mem_we;

    int checks_total  = 0;
    int checks_passed = 0;

    memory_arbiter #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_req         (i_req),
        .i_address     (i_address),
        .i_data        (i_data),
        .i_ack         (i_ack),
        .i_err         (i_err),
        .d_req         (d_req),
        .d_we          (d_we),
        .d_address     (d_address),
        .d_write_data  (d_write_data),
        .d_read_data   (d_read_data),
        .d_ack         (d_ack),
        .d_err         (d_err),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_address   (mem_address),
        .mem_write_data(mem_write_data),
        .mem_read_data (mem_read_data),
        .mem_ack       (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves mem_ack low for 'delay' ACCESS cycles, then acks once; returns in the RESPOND cycle.
    task automatic do_ack(input int delay, input logic [31:0] rdata);
        for (int k = 0; k < delay; k++) tick();
        mem_ack       = 1'b1;
        mem_read_data = rdata;
        tick();
        mem_ack = 1'b0;
    endtask

    logic [3:0] exp_order;  // bit t = 1 when transaction t goes to the data port

    initial begin
`ifdef ROUND_ROBIN_EN
        exp_order = 4'b1010;
`else
        exp_order = 4'b1111;
`endif
        reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
        i_address = '0; d_address = '0; d_write_data = '0; mem_read_data = '0;
        tick(); tick();
        reset = 1'b0;
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_acks", {28'd0, i_ack, i_err, d_ack, d_err}, 32'd0);
        check("rst_i_data", i_data, 32'd0);
        check("rst_d_read_data", d_read_data, 32'd0);
        check("rst_mem_bus", mem_address | mem_write_data | {31'd0, mem_we}, 32'd0);

        // Scenario 1: instruction fetch
        i_req = 1'b1; i_address = 32'h10;
        tick();
        check("s1_mem_req", {31'd0, mem_req}, 32'd1);
        check("s1_mem_address", mem_address, 32'h10);
        check("s1_mem_we", {31'd0, mem_we}, 32'd0);
        check("s1_no_early_ack", {31'd0, i_ack}, 32'd0);
        do_ack(1, 32'h00500093);
        check("s1_i_ack", {31'd0, i_ack}, 32'd1);
        check("s1_i_data", i_data, 32'h00500093);
        check("s1_i_err", {31'd0, i_err}, 32'd0);
        check("s1_d_ack_quiet", {31'd0, d_ack}, 32'd0);
        check("s1_mem_req_drop", {31'd0, mem_req}, 32'd0);
        i_req = 1'b0;
        tick();
        check("s1_i_ack_pulse", {31'd0, i_ack}, 32'd0);
        check("s1_i_data_hold", i_data, 32'h00500093);

        // Data read to give d_read_data a known non-zero value
        d_req = 1'b1; d_we = 1'b0; d_address = 32'h300;
        tick();
        do_ack(0, 32'hCAFEF00D);
        check("rd_d_ack", {31'd0, d_ack}, 32'd1);
        check("rd_d_data", d_read_data, 32'hCAFEF00D);
        check("rd_i_data_kept", i_data, 32'h00500093);
        d_req = 1'b0;
        tick();

        // Scenario 2: write, ack in the 4th ACCESS cycle (coincides with the timeout)
        d_req = 1'b1; d_we = 1'b1; d_address = 32'h200; d_write_data = 32'hDEADBEEF;
        tick();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("s2_mem_req_%0d", k), {31'd0, mem_req}, 32'd1);
            check($sformatf("s2_mem_we_%0d", k), {31'd0, mem_we}, 32'd1);
            check($sformatf("s2_wdata_%0d", k), mem_write_data, 32'hDEADBEEF);
            if (k == 3) begin
                mem_ack = 1'b1; mem_read_data = 32'h12345678;
            end
            tick();
        end
        mem_ack = 1'b0;
        check("s2_mem_address", mem_address, 32'h200);
        check("s2_d_ack", {31'd0, d_ack}, 32'd1);
        check("s2_d_err", {31'd0, d_err}, 32'd0);
        check("s2_d_read_kept", d_read_data, 32'hCAFEF00D);
        d_req = 1'b0; d_we = 1'b0;
        tick();
        check("s2_d_ack_pulse", {31'd0, d_ack}, 32'd0);

        // Scenario 3: both ports requesting for four transactions
        i_req = 1'b1; i_address = 32'h40; d_req = 1'b1; d_address = 32'h80;
        for (int t = 0; t < 4; t++) begin
            tick();
            check($sformatf("s3_addr_%0d", t), mem_address, exp_order[t] ? 32'h80 : 32'h40);
            do_ack(0, 32'h1000 + t);
            check($sformatf("s3_d_ack_%0d", t), {31'd0, d_ack}, {31'd0, exp_order[t]});
            check($sformatf("s3_i_ack_%0d", t), {31'd0, i_ack}, {31'd0, ~exp_order[t]});
            if (t == 3) begin
                i_req = 1'b0; d_req = 1'b0;
            end
            tick();
            check($sformatf("s3_gap_%0d", t), {31'd0, mem_req}, 32'd0);
        end
        check("s3_d_last", d_read_data, 32'h1003);

        // Scenario 4: timeout after four ACCESS cycles
        d_req = 1'b1; d_address = 32'h400;
        tick();
        tick(); tick(); tick();
        check("s4_still_access", {31'd0, mem_req}, 32'd1);
        check("s4_no_ack_yet", {31'd0, d_ack}, 32'd0);
        tick();
        check("s4_d_ack", {31'd0, d_ack}, 32'd1);
        check("s4_d_err", {31'd0, d_err}, 32'd1);
        check("s4_d_data_zero", d_read_data, 32'd0);
        check("s4_mem_req_drop", {31'd0, mem_req}, 32'd0);
        d_req = 1'b0;
        tick();
        check("s4_err_with_ack", {30'd0, d_ack, d_err}, 32'd0);

        d_req = 1'b1;
        tick();
        do_ack(3, 32'hA5A5A5A5);
        check("s4b_d_ack", {31'd0, d_ack}, 32'd1);
        check("s4b_d_err", {31'd0, d_err}, 32'd0);
        check("s4b_d_data", d_read_data, 32'hA5A5A5A5);
        d_req = 1'b0;
        tick();

        // Scenario 5: reset during ACCESS, stale mem_ack afterwards
        i_req = 1'b1; i_address = 32'h80;
        tick();
        check("s5_mem_req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        tick();
        check("s5_rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("s5_rst_d_data", d_read_data, 32'd0);
        reset = 1'b0; i_req = 1'b0; mem_ack = 1'b1; mem_read_data = 32'h00000BAD;
        tick();
        check("s5_stale_acks", {30'd0, i_ack, d_ack}, 32'd0);
        check("s5_idle_mem_req", {31'd0, mem_req}, 32'd0);
        tick();
        check("s5_stale_acks2", {30'd0, i_ack, d_ack}, 32'd0);
        check("s5_i_data", i_data, 32'd0);
        mem_ack = 1'b0;
        d_req = 1'b1; d_address = 32'h500;
        tick();
        check("s5_next_mem_req", {31'd0, mem_req}, 32'd1);
        check("s5_next_addr", mem_address, 32'h500);
        do_ack(0, 32'h0000600D);
        check("s5_next_d_ack", {31'd0, d_ack}, 32'd1);
        check("s5_next_d_data", d_read_data, 32'h0000600D);
        d_req = 1'b0;
        tick();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL have parameter ADDRESS_WIDTH, default 32, width of every address bus.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, width of every data bus.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum number of ACCESS cycles before a bus error; legal range 1..65535.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-006 The block SHALL have ports i_req in 1, i_address in ADDRESS_WIDTH, i_data out DATA_WIDTH, i_ack out 1 and i_err out 1, forming the instruction-fetch read port.
REQ-007 The block SHALL have ports d_req in 1, d_we in 1, d_address in ADDRESS_WIDTH, d_write_data in DATA_WIDTH, d_read_data out DATA_WIDTH, d_ack out 1 and d_err out 1, forming the load/store port.
REQ-008 The block SHALL have ports mem_req out 1, mem_we out 1, mem_address out ADDRESS_WIDTH, mem_write_data out DATA_WIDTH, mem_read_data in DATA_WIDTH and mem_ack in 1, forming the shared memory port.

Function
REQ-009 The block SHALL implement the FSM states IDLE, ACCESS and RESPOND.
REQ-010 In IDLE with any req high, the block SHALL grant one port, register its address, we and write data (we=0 for instruction), and enter ACCESS.
REQ-011 In ACCESS, the block SHALL hold mem_req=1 and the registered mem_address/mem_we/mem_write_data stable every cycle; mem_req is therefore first high one cycle after the grant.
REQ-012 On mem_ack=1 in ACCESS, the block SHALL capture mem_read_data into the granted port's data output and enter RESPOND.
REQ-013 In RESPOND, the block SHALL assert the granted port's ack for exactly one cycle, drive mem_req=0, ignore all req inputs, then return to IDLE.
REQ-014 A requester SHALL hold req, address and write data stable until its ack; the earliest next grant is the cycle after RESPOND.
REQ-015 Latency SHALL be: req sampled at edge N -> mem_req high from N+1; mem_ack at edge M -> ack and data valid at M+1.
REQ-016 Read data outputs SHALL hold their last captured value until the next completion on the same port; d_read_data is unchanged by write completions.
REQ-017 A 16-bit counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without mem_ack.
REQ-018 If the counter reaches TIMEOUT_CYCLES without mem_ack, the block SHALL enter RESPOND with ack=1, err=1 and data=0 on the granted port.
REQ-019 mem_ack in the same cycle as the timeout SHALL win: normal completion, err=0.
REQ-020 mem_ack while in IDLE or RESPOND SHALL be ignored.
REQ-021 i_err and d_err SHALL be asserted only together with their ack.
REQ-022 On simultaneous i_req and d_req in IDLE, priority SHALL follow the Configuration rules; a single request is always granted.

Reset
REQ-023 Reset SHALL force state IDLE, counter 0, and every output to 0, including mem_req, acks, errs and all data/address outputs.
REQ-024 Reset during ACCESS or RESPOND SHALL abort the transfer without issuing an ack; mem_req is 0 from the first reset edge.
REQ-025 A mem_ack for the aborted transfer arriving after reset SHALL be ignored per REQ-020.

Configuration
REQ-026 Macro ROUND_ROBIN_EN undefined: on a simultaneous request, the data port SHALL always win.
REQ-027 Macro ROUND_ROBIN_EN defined: a last_grant register, reset to data, SHALL be updated on each grant; on a simultaneous request, the port not granted last SHALL win.

Verification
REQ-028 Scenario 1: i_req=1, i_address=0x10, mem_ack one cycle after mem_req with mem_read_data=0x00500093 -> mem_address=0x10, mem_we=0, i_ack pulses 1 cycle with i_data=0x00500093, i_err=0.
REQ-029 Scenario 2: d_req=1, d_we=1, d_address=0x200, d_write_data=0xDEADBEEF, mem_ack after 3 cycles -> mem_we=1, mem_write_data=0xDEADBEEF held 4 cycles, d_ack one pulse, d_read_data unchanged.
REQ-030 Scenario 3: i_req and d_req both held high for 4 transactions -> without ROUND_ROBIN_EN grant order D,D,D,D; with it, order I,D,I,D.
REQ-031 Scenario 4: TIMEOUT_CYCLES=4, d_req=1, mem_ack never asserted -> d_ack=1, d_err=1, d_read_data=0 after 4 ACCESS cycles; repeat with mem_ack on the 4th cycle -> d_err=0.
REQ-032 Scenario 5: reset pulsed during ACCESS, then mem_ack=1 -> no ack on either port, mem_req=0, state IDLE, and the next request is served normally.
